// File: rtl/fpu_cmp_pkg.sv
// Shared opcode/state types and IEEE-754 binary32 NaN helpers for the compare unit.
// No logic of its own; latency not applicable.
// Backpressure not applicable.
package fpu_cmp_pkg;

    typedef enum logic [2:0] {
        OP_FEQ  = 3'd0,
        OP_FLT  = 3'd1,
        OP_FLE  = 3'd2,
        OP_FMIN = 3'd3,
        OP_FMAX = 3'd4
    } fcmp_op_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } resp_state_e;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } fcmp_req_t;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_snan(input logic [31:0] x);
        return is_nan(x) && !x[22];
    endfunction

endpackage

// File: rtl/fcmp_core.sv
// Single-precision FEQ/FLT/FLE/FMIN/FMAX evaluator with IEEE invalid flag.
// Purely combinational, zero latency.
// No flow control; caller qualifies inputs.
module fcmp_core
    import fpu_cmp_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] result,
    output logic        invalid
);

    logic a_nan;
    logic b_nan;
    logic any_nan;
    logic any_snan;
    logic both_zero;
    logic a_eq_b;
    logic a_lt_b;

    always_comb begin
        a_nan     = is_nan(a);
        b_nan     = is_nan(b);
        any_nan   = a_nan | b_nan;
        any_snan  = is_snan(a) | is_snan(b);
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        a_eq_b    = both_zero || (a == b);
        // Sign-magnitude order: magnitude comparison flips when both are negative.
        if (both_zero) begin
            a_lt_b = 1'b0;
        end else if (a[31] != b[31]) begin
            a_lt_b = a[31];
        end else if (a[31]) begin
            a_lt_b = a[30:0] > b[30:0];
        end else begin
            a_lt_b = a[30:0] < b[30:0];
        end
    end

    always_comb begin
        result  = 32'd0;
        invalid = 1'b0;
        case (op)
            OP_FEQ: begin
                result  = {31'd0, !any_nan && a_eq_b};
                invalid = any_snan;
            end
            OP_FLT: begin
                result  = {31'd0, !any_nan && a_lt_b};
                invalid = any_nan;
            end
            OP_FLE: begin
                result  = {31'd0, !any_nan && (a_lt_b || a_eq_b)};
                invalid = any_nan;
            end
            OP_FMIN, OP_FMAX: begin
                invalid = any_snan;
                if (a_nan && b_nan) begin
                    result = CANON_NAN;
                end else if (a_nan) begin
                    result = b;
                end else if (b_nan) begin
                    result = a;
                end else if (both_zero) begin
                    result = (op == OP_FMIN) ? {a[31] | b[31], 31'd0} : {a[31] & b[31], 31'd0};
                end else if (a_lt_b ^ (op == OP_FMAX)) begin
                    result = a;
                end else begin
                    result = b;
                end
            end
            default: begin
                result  = 32'd0;
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fcmp_sched.sv
// Round-robin arbiter sharing one fcmp_core among N_REQ requesters, registered tagged response.
// Latency: accepted on edge k, result visible on resp_* from edge k.
// Backpressure: no grants and rr_ptr frozen while the response slot is full and not drained.
module fcmp_sched
    import fpu_cmp_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [3*N_REQ-1:0]   req_op,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [ID_W-1:0]      resp_id,
    output logic [31:0]          resp_result,
    output logic                 resp_invalid
);

    localparam logic [ID_W:0]   N_EXT    = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_REQ - 1);

    fcmp_req_t req_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign req_arr[g] = {req_op[3*g +: 3], req_a[32*g +: 32], req_b[32*g +: 32]};
    end

    resp_state_e     state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [31:0]     resp_result_q, resp_result_d;
    logic            resp_invalid_q, resp_invalid_d;

    logic            slot_free;
    logic            grant_found;
    logic            grant_vld;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W:0]   cand;
    fcmp_req_t       sel_req;
    logic [31:0]     core_result;
    logic            core_invalid;

    // Wrap-around search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < N_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (ID_W+1)'(off);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[ID_W-1:0];
            end
        end
    end

    assign slot_free = (state_q == ST_EMPTY) | resp_ready;
    assign grant_vld = grant_found & slot_free & !rst;
    assign sel_req   = req_arr[grant_idx];

    fcmp_core u_core (
        .op      (sel_req.op),
        .a       (sel_req.a),
        .b       (sel_req.b),
        .result  (core_result),
        .invalid (core_invalid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_EMPTY;
            rr_ptr_q       <= '0;
            resp_id_q      <= '0;
            resp_result_q  <= 32'd0;
            resp_invalid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rr_ptr_q       <= rr_ptr_d;
            resp_id_q      <= resp_id_d;
            resp_result_q  <= resp_result_d;
            resp_invalid_q <= resp_invalid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (grant_vld) state_d = ST_FULL;
            ST_FULL:  if (!grant_vld && resp_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    // A grant while FULL implies resp_ready, so drain and reload share one edge.
    always_comb begin
        rr_ptr_d       = rr_ptr_q;
        resp_id_d      = resp_id_q;
        resp_result_d  = resp_result_q;
        resp_invalid_d = resp_invalid_q;
        if (grant_vld) begin
            rr_ptr_d       = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
            resp_id_d      = grant_idx;
            resp_result_d  = core_result;
            resp_invalid_d = core_invalid;
        end
    end

    always_comb begin
        resp_valid   = (state_q == ST_FULL);
        resp_id      = resp_id_q;
        resp_result  = resp_result_q;
        resp_invalid = resp_invalid_q;
        req_ready    = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

endmodule

// File: tb/tb_fcmp_sched.sv
// Directed and random checks of fcmp_sched against a key-based float ordering model.
module tb_fcmp_sched;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [11:0]   req_op;
    logic [127:0]  req_a;
    logic [127:0]  req_b;
    logic          resp_valid;
    logic          resp_ready;
    logic [1:0]    resp_id;
    logic [31:0]   resp_result;
    logic          resp_invalid;

    fcmp_sched #(.N_REQ(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_result  (resp_result),
        .resp_invalid (resp_invalid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        v   [N];
    logic [2:0]  opv [N];
    logic [31:0] av  [N];
    logic [31:0] bv  [N];

    logic        m_vld;
    int          m_id;
    logic [31:0] m_res;
    logic        m_inv;
    int          m_rr;
    int          granted;
    int          exp_order [5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic fnan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    // Total-order key: signed magnitude, with +0 and -0 mapping to the same value.
    function automatic longint fkey(input logic [31:0] x);
        longint mag;
        mag = longint'(x[30:0]);
        return x[31] ? -mag : mag;
    endfunction

    task automatic ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic inv);
        logic   an, bn, as_, bs_;
        longint ka, kb;
        an  = fnan(a);
        bn  = fnan(b);
        as_ = an && !a[22];
        bs_ = bn && !b[22];
        ka  = fkey(a);
        kb  = fkey(b);
        r   = 32'd0;
        inv = 1'b0;
        case (o)
            3'd0: begin r = {31'd0, !an && !bn && ka == kb}; inv = as_ || bs_; end
            3'd1: begin r = {31'd0, !an && !bn && ka < kb};  inv = an || bn;   end
            3'd2: begin r = {31'd0, !an && !bn && ka <= kb}; inv = an || bn;   end
            3'd3, 3'd4: begin
                inv = as_ || bs_;
                if (an && bn)     r = 32'h7FC0_0000;
                else if (an)      r = b;
                else if (bn)      r = a;
                else if (ka < kb) r = (o == 3'd3) ? a : b;
                else if (kb < ka) r = (o == 3'd3) ? b : a;
                else              r = (o == 3'd3) ? (a[31] ? a : b) : (a[31] ? b : a);
            end
            default: begin r = 32'd0; inv = 1'b1; end
        endcase
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [12];
        pool = '{32'h0000_0000, 32'h8000_0000, 32'h3F80_0000, 32'h4000_0000,
                 32'hBF80_0000, 32'hC000_0000, 32'h7FC0_0000, 32'h7F80_0001,
                 32'hFFC0_0001, 32'h7F80_0000, 32'hFF80_0000, 32'h0000_0001};
        if ($urandom_range(0, 2) == 0) return $urandom();
        return pool[$urandom_range(0, 11)];
    endfunction

    task automatic renew(input int i);
        opv[i] = 3'($urandom_range(0, 7));
        av[i]  = pick_operand();
        bv[i]  = pick_operand();
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = v[i];
            req_op[3*i +: 3]   = opv[i];
            req_a[32*i +: 32]  = av[i];
            req_b[32*i +: 32]  = bv[i];
        end
    endtask

    task automatic model_reset();
        m_vld = 1'b0; m_id = 0; m_res = 32'd0; m_inv = 1'b0; m_rr = 0;
    endtask

    // One clock: check comb grant and registered response, then advance the model past the edge.
    task automatic cycle();
        int          g;
        logic [3:0]  er;
        logic [31:0] r;
        logic        inv;
        drive();
        #1;
        g  = -1;
        er = 4'd0;
        if (!m_vld || resp_ready) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(er));
        check("resp_valid", 32'(resp_valid), 32'(m_vld));
        if (m_vld) begin
            check("resp_id", 32'(resp_id), 32'(m_id));
            check("resp_result", resp_result, m_res);
            check("resp_invalid", 32'(resp_invalid), 32'(m_inv));
        end
        @(posedge clk);
        if (g >= 0) begin
            ref_op(opv[g], av[g], bv[g], r, inv);
            m_vld = 1'b1; m_id = g; m_res = r; m_inv = inv;
            m_rr  = (g + 1) % N;
        end else if (resp_ready) begin
            m_vld = 1'b0;
        end
        granted = g;
        #1;
    endtask

    task automatic solo(input string tag, input int i, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input logic ei);
        v[i] = 1'b1; opv[i] = o; av[i] = a; bv[i] = b;
        cycle();
        v[i] = 1'b0;
        check({tag, "_valid"}, 32'(resp_valid), 32'd1);
        check({tag, "_id"}, 32'(resp_id), 32'(i));
        check({tag, "_res"}, resp_result, er);
        check({tag, "_inv"}, 32'(resp_invalid), 32'(ei));
    endtask

    initial begin
        rst = 1'b1;
        resp_ready = 1'b1;
        granted = -1;
        for (int i = 0; i < N; i++) begin
            v[i] = 1'b1; opv[i] = 3'd0; av[i] = 32'd0; bv[i] = 32'd0;
        end
        drive();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_result", resp_result, 32'd0);
        check("rst_resp_invalid", 32'(resp_invalid), 32'd0);
        rst = 1'b0;

        // All requesters valid: strict rotation, one response per cycle.
        for (int i = 0; i < N; i++) renew(i);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_order_valid", 32'(resp_valid), 32'd1);
            check("rr_order_id", 32'(resp_id), 32'(exp_order[k]));
            renew(granted);
        end
        for (int i = 0; i < N; i++) v[i] = 1'b0;

        solo("flt_1_2",     0, 3'd1, 32'h3F80_0000, 32'h4000_0000, 32'd1, 1'b0);
        solo("fle_neg1_m0", 0, 3'd2, 32'hBF80_0000, 32'h8000_0000, 32'd1, 1'b0);
        solo("feq_p0_m0",   0, 3'd0, 32'h0000_0000, 32'h8000_0000, 32'd1, 1'b0);
        solo("fmin_qnan",   0, 3'd3, 32'h7FC0_0001, 32'h4000_0000, 32'h4000_0000, 1'b0);
        solo("fmax_snan",   0, 3'd4, 32'h7F80_0001, 32'h7FC0_0000, 32'h7FC0_0000, 1'b1);
        solo("flt_qnan",    0, 3'd1, 32'h7FC0_0000, 32'h3F80_0000, 32'd0, 1'b1);
        solo("feq_qnan",    0, 3'd0, 32'h7FC0_0000, 32'h7FC0_0000, 32'd0, 1'b0);
        solo("fmin_zeros",  0, 3'd3, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);
        solo("fmax_zeros",  0, 3'd4, 32'h8000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
        solo("fmin_bothnan",0, 3'd3, 32'hFFC0_0001, 32'h7F80_0002, 32'h7FC0_0000, 1'b1);
        solo("fmax_negs",   0, 3'd4, 32'hC000_0000, 32'hBF80_0000, 32'hBF80_0000, 1'b0);
        solo("reserved_op", 0, 3'd6, 32'h3F80_0000, 32'h4000_0000, 32'd0, 1'b1);

        // Back-pressure with requesters 1 and 2 pending; rr_ptr is 1 here.
        v[1] = 1'b1; renew(1);
        v[2] = 1'b1; renew(2);
        cycle();
        check("bp_first_id", 32'(resp_id), 32'd1);
        renew(1);
        resp_ready = 1'b0;
        repeat (3) begin
            cycle();
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_hold_id", 32'(resp_id), 32'd1);
        end
        resp_ready = 1'b1;
        cycle();
        check("bp_release_valid", 32'(resp_valid), 32'd1);
        check("bp_release_id", 32'(resp_id), 32'd2);

        // Reset while FULL; requester 3 alone afterwards.
        v[1] = 1'b0; v[2] = 1'b0; v[3] = 1'b1; renew(3);
        drive();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(resp_valid), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_result", resp_result, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("post_rst_sole3_id", 32'(resp_id), 32'd3);

        // Reset again with 1 and 3 pending: pointer restarts at 0 so 1 wins.
        v[1] = 1'b1; renew(1); renew(3);
        drive();
        rst = 1'b1;
        #1;
        check("mid_rst2_valid", 32'(resp_valid), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();
        check("post_rst_pair_id", 32'(resp_id), 32'd1);

        // Random traffic with random consumer stalls.
        for (int n = 0; n < 600; n++) begin
            resp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!v[i] || granted == i) begin
                    v[i] = 1'($urandom_range(0, 1));
                    if (v[i]) renew(i);
                end
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
